// File: rtl/gpr_multiport_sb.sv
// Multi-port general-purpose register file with write-first bypass and a
// per-register pending scoreboard for in-order issue / out-of-order writeback.
module gpr_multiport_sb #(
    parameter int DATA_WIDTH = 64,
    parameter int RF_SIZE    = 5,
    parameter int NR_READ    = 2,
    parameter int NR_WRITE   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NR_READ*RF_SIZE-1:0]     rs,
    output logic [NR_READ*DATA_WIDTH-1:0]  rdata,
    output logic [NR_READ-1:0]             rbusy,
    input  logic [NR_WRITE-1:0]            we,
    input  logic [NR_WRITE*RF_SIZE-1:0]    wd,
    input  logic [NR_WRITE*DATA_WIDTH-1:0] wdata,
    input  logic                           claim_valid,
    input  logic [RF_SIZE-1:0]             claim_rd,
    output logic                           claim_ready,
    output logic [RF_SIZE:0]               pending_count
);

    localparam int NREG = 1 << RF_SIZE;

    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]       pending;

    logic [RF_SIZE-1:0]    widx [NR_WRITE];
    logic [DATA_WIDTH-1:0] wval [NR_WRITE];
    logic [NR_WRITE-1:0]   wvalid;
    logic [RF_SIZE-1:0]    ridx [NR_READ];
    logic                  claim_hit;
    logic                  claim_accept;

    // Writes to x0 are dropped here so every consumer sees only effective writes.
    always_comb begin
        for (int j = 0; j < NR_WRITE; j++) begin
            widx[j]   = wd[j*RF_SIZE +: RF_SIZE];
            wval[j]   = wdata[j*DATA_WIDTH +: DATA_WIDTH];
            wvalid[j] = we[j] && (widx[j] != '0);
        end
    end

    always_comb begin
        // NOTE: outputs get a default before the loops so no path can infer a latch.
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NR_READ; i++) begin
            ridx[i] = rs[i*RF_SIZE +: RF_SIZE];
            rdata[i*DATA_WIDTH +: DATA_WIDTH] = regs[ridx[i]];
            rbusy[i] = pending[ridx[i]];
            // Ascending scan: the highest-index matching write port is the one seen.
            for (int j = 0; j < NR_WRITE; j++) begin
                if (wvalid[j] && (widx[j] == ridx[i])) begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] = wval[j];
                    rbusy[i] = 1'b0;
                end
            end
            if (ridx[i] == '0) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                rbusy[i] = 1'b0;
            end
        end
    end

    // A write retiring the claimed register this cycle resolves the WAW hazard.
    always_comb begin
        claim_hit = 1'b0;
        for (int j = 0; j < NR_WRITE; j++) begin
            if (wvalid[j] && (widx[j] == claim_rd)) claim_hit = 1'b1;
        end
        claim_ready  = (claim_rd == '0) || !pending[claim_rd] || claim_hit;
        claim_accept = claim_valid && claim_ready && (claim_rd != '0);
    end

    always_comb begin
        pending_count = '0;
        for (int k = 0; k < NREG; k++) begin
            pending_count = pending_count + (RF_SIZE+1)'(pending[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data array is reset too, since never-written registers must read as 0.
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
            pending <= '0;
        end else begin
            // NOTE: non-blocking updates; a later port's assignment overrides an earlier one,
            // so the highest-index port wins a collision, and the claim below wins over a clear.
            for (int j = 0; j < NR_WRITE; j++) begin
                if (wvalid[j]) begin
                    regs[widx[j]]    <= wval[j];
                    pending[widx[j]] <= 1'b0;
                end
            end
            if (claim_accept) pending[claim_rd] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gpr_multiport_sb.sv
// Bench for gpr_multiport_sb: directed scenarios plus randomized traffic, all
// checked every cycle against a register/pending array model.
module tb_gpr_multiport_sb;

    localparam int DW   = 64;
    localparam int RSZ  = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int NREG = 32;

    logic                clk;
    logic                rst_n;
    logic [NRD*RSZ-1:0]  rs;
    logic [NRD*DW-1:0]   rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we;
    logic [NWR*RSZ-1:0]  wd;
    logic [NWR*DW-1:0]   wdata;
    logic                claim_valid;
    logic [RSZ-1:0]      claim_rd;
    logic                claim_ready;
    logic [RSZ:0]        pending_count;

    gpr_multiport_sb #(
        .DATA_WIDTH(DW), .RF_SIZE(RSZ), .NR_READ(NRD), .NR_WRITE(NWR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rdata(rdata), .rbusy(rbusy),
        .we(we), .wd(wd), .wdata(wdata), .claim_valid(claim_valid),
        .claim_rd(claim_rd), .claim_ready(claim_ready), .pending_count(pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural model: register values and pending flags by index.
    logic [DW-1:0] m_mem  [NREG];
    bit            m_pend [NREG];
    logic [DW-1:0] m_d;
    bit            m_acc;

    // Value written to register r this cycle (last enabled port wins), if any.
    function automatic bit wr_hit(input int r, output logic [DW-1:0] v);
        wr_hit = 1'b0;
        v = '0;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && wd[j*RSZ +: RSZ] != 0 && int'(wd[j*RSZ +: RSZ]) == r) begin
                wr_hit = 1'b1;
                v = wdata[j*DW +: DW];
            end
        end
    endfunction

    function automatic bit m_ready();
        logic [DW-1:0] d;
        int r;
        r = int'(claim_rd);
        return (r == 0) || !m_pend[r] || wr_hit(r, d);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < NREG; k++) c += int'(m_pend[k]);
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                m_mem[k]  = '0;
                m_pend[k] = 1'b0;
            end
        end else begin
            m_acc = claim_valid && m_ready() && (claim_rd != 0);
            for (int r = 1; r < NREG; r++) begin
                if (wr_hit(r, m_d)) begin
                    m_mem[r]  = m_d;
                    m_pend[r] = 1'b0;
                end
            end
            if (m_acc) m_pend[claim_rd] = 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    int            c_r;
    logic [DW-1:0] c_d;
    logic [DW-1:0] c_ed;
    bit            c_eb;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NRD; i++) begin
                c_r = int'(rs[i*RSZ +: RSZ]);
                if (c_r == 0) begin
                    c_ed = '0; c_eb = 1'b0;
                end else if (wr_hit(c_r, c_d)) begin
                    c_ed = c_d; c_eb = 1'b0;
                end else begin
                    c_ed = m_mem[c_r]; c_eb = m_pend[c_r];
                end
                check($sformatf("rdata%0d_x%0d", i, c_r), rdata[i*DW +: DW], c_ed);
                check($sformatf("rbusy%0d_x%0d", i, c_r), rbusy[i], c_eb);
            end
            check("claim_ready", claim_ready, m_ready());
            check("pending_count", pending_count, m_count());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input int i, input int idx);
        rs[i*RSZ +: RSZ] = idx[RSZ-1:0];
    endtask

    task automatic set_w(input int j, input bit en, input int idx, input logic [DW-1:0] d);
        we[j] = en;
        wd[j*RSZ +: RSZ] = idx[RSZ-1:0];
        wdata[j*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        we = '0; wd = '0; wdata = '0; claim_valid = 1'b0; claim_rd = '0;
    endtask

    initial begin
        rs = '0;
        idle_inputs();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        step();

        // Reset discards data and pending state.
        set_w(0, 1, 5, 64'hDEAD); claim_valid = 1'b1; claim_rd = 5'd6;
        step();
        idle_inputs(); set_rs(0, 5); set_rs(1, 6);
        #1;
        check("pre_reset_x5", rdata[DW-1:0], 64'hDEAD);
        check("pre_reset_busy_x6", rbusy[1], 1'b1);
        rst_n = 1'b0;
        claim_rd = 5'd6;
        #1;
        check("reset_x5", rdata[DW-1:0], 64'h0);
        check("reset_rbusy", rbusy, 2'b00);
        check("reset_claim_ready", claim_ready, 1'b1);
        check("reset_count", pending_count, 6'd0);
        rst_n = 1'b1;
        step();
        check("post_reset_x5", rdata[DW-1:0], 64'h0);

        // Same-cycle bypass and x0 handling.
        claim_rd = '0;
        set_rs(0, 3); set_rs(1, 0); set_w(0, 1, 3, 64'h1234);
        #1;
        check("bypass_x3", rdata[DW-1:0], 64'h1234);
        check("bypass_x0", rdata[2*DW-1:DW], 64'h0);
        step();
        idle_inputs();
        #1;
        check("stored_x3", rdata[DW-1:0], 64'h1234);
        set_rs(0, 0); set_w(0, 1, 0, 64'hFF);
        #1;
        check("write_x0_bypass", rdata[DW-1:0], 64'h0);
        step();
        idle_inputs();
        #1;
        check("write_x0_stored", rdata[DW-1:0], 64'h0);

        // Write collision: highest port wins.
        set_rs(0, 7); set_w(0, 1, 7, 64'hAAAA); set_w(1, 1, 7, 64'hBBBB);
        #1;
        check("collide_bypass", rdata[DW-1:0], 64'hBBBB);
        step();
        idle_inputs();
        #1;
        check("collide_stored", rdata[DW-1:0], 64'hBBBB);

        // Scoreboard claim / stall / clear.
        set_rs(0, 10); claim_valid = 1'b1; claim_rd = 5'd10;
        #1;
        check("claim10_ready", claim_ready, 1'b1);
        step();
        #1;
        check("claim10_busy", rbusy[0], 1'b1);
        check("claim10_count", pending_count, 6'd1);
        check("claim10_waw_stall", claim_ready, 1'b0);
        step();
        check("stall_no_change", pending_count, 6'd1);
        claim_valid = 1'b0; set_w(0, 1, 10, 64'h42);
        #1;
        check("clear10_busy", rbusy[0], 1'b0);
        check("clear10_bypass", rdata[DW-1:0], 64'h42);
        step();
        idle_inputs();
        #1;
        check("clear10_count", pending_count, 6'd0);

        // Claim wins over a same-cycle clearing write.
        set_rs(0, 12); claim_valid = 1'b1; claim_rd = 5'd12;
        step();
        set_w(1, 1, 12, 64'h77);
        #1;
        check("claim_vs_write_ready", claim_ready, 1'b1);
        step();
        idle_inputs();
        #1;
        check("claim_vs_write_busy", rbusy[0], 1'b1);
        check("claim_vs_write_data", rdata[DW-1:0], 64'h77);
        check("claim_vs_write_count", pending_count, 6'd1);
        set_w(0, 1, 12, 64'h78);
        step();
        idle_inputs();

        // Fill every claimable register.
        for (int r = 1; r < NREG; r++) begin
            claim_valid = 1'b1; claim_rd = r[RSZ-1:0];
            step();
        end
        claim_valid = 1'b0;
        #1;
        check("fill_count", pending_count, 6'd31);
        claim_valid = 1'b1; claim_rd = '0;
        #1;
        check("claim_x0_ready", claim_ready, 1'b1);
        step();
        claim_valid = 1'b0;
        #1;
        check("claim_x0_count", pending_count, 6'd31);

        // Randomized traffic, one asynchronous reset pulse in the middle.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NRD; i++) set_rs(i, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            for (int j = 0; j < NWR; j++)
                set_w(j, $urandom_range(0, 2) == 0,
                      ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                      {$urandom, $urandom});
            claim_valid = $urandom_range(0, 1) != 0;
            claim_rd = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            if (n == 1500) begin
                #1 rst_n = 1'b0;
                #1;
                check("mid_reset_count", pending_count, 6'd0);
                rst_n = 1'b1;
            end
            step();
        end
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_multiport_sb.md
# gpr_multiport_sb

Parametrised successor to the single-write general-purpose register file: NR_READ combinational read ports, NR_WRITE synchronous write ports with write-first bypass, and an integrated per-register scoreboard (pending bits) for in-order issue/out-of-order writeback pipelines. It sits between decode/issue, which reads operands and claims destinations, and the writeback stage(s), which retire results. Register 0 is hardwired to zero and never pending.

## Interface
Parameters:
- DATA_WIDTH, 64, register width in bits
- RF_SIZE, 5, index width; the file holds 2**RF_SIZE registers
- NR_READ, 2, number of read ports (≥1)
- NR_WRITE, 2, number of write ports (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs  in  NR_READ*RF_SIZE  read indices; port i at bits [i*RF_SIZE +: RF_SIZE]
- rdata  out  NR_READ*DATA_WIDTH  read data, packed like rs
- rbusy  out  NR_READ  port i's register is pending and not written this cycle
- we  in  NR_WRITE  write enable per write port
- wd  in  NR_WRITE*RF_SIZE  write indices
- wdata  in  NR_WRITE*DATA_WIDTH  write data
- claim_valid  in  1  issue requests to mark claim_rd pending
- claim_rd  in  RF_SIZE  destination being claimed
- claim_ready  out  1  claim may be accepted this cycle
- pending_count  out  RF_SIZE+1  number of registers currently pending

## Operation
- Storage: 2**RF_SIZE × DATA_WIDTH registers plus 2**RF_SIZE pending bits.
- Write: port j with we[j]=1 and wd[j]≠0 writes wdata[j] at the edge and clears pending[wd[j]]. Writes to index 0 are discarded.
- Write collision: several ports with the same nonzero wd in one cycle → highest-index port wins, both for storage and bypass.
- Read (combinational): rdata[i] = 0 if rs[i]=0; else wdata of the highest-index port writing rs[i] this cycle; else stored value.
- rbusy[i] = pending[rs[i]] AND no enabled write to rs[i] this cycle; always 0 for rs[i]=0.
- claim_ready = (claim_rd=0) OR !pending[claim_rd] OR an enabled write targets claim_rd this cycle (WAW stall otherwise).
- Claim accepted when claim_valid && claim_ready: pending[claim_rd] set at the edge (no-op for index 0). A claim wins over a same-cycle clearing write to the same register: pending stays 1, data is updated.
- claim_valid && !claim_ready: no state change; issuer must hold and retry.
- pending_count = popcount of pending bits (registered value, not including same-cycle events).

## Timing
- Reset (rst_n low, asynchronous): all registers 0, all pending 0; hence rdata=0, rbusy=0, claim_ready=1, pending_count=0 while held and after release.
- Read latency 0 cycles (combinational from rs, we, wd, wdata and state).
- Write visible via bypass in the same cycle; from storage from the next cycle.
- Claim → rbusy asserted for readers of that register from the next cycle; pending_count increments next cycle.
- Write clearing pending → rbusy drops in the same cycle (bypass) and pending_count decrements next cycle.
- Reset mid-operation: all pending and data discarded immediately; in-flight writes in that cycle are lost.
- Max pending_count is 2**RF_SIZE−1 (x0 never pending); width RF_SIZE+1 avoids overflow.

## Test plan
- Reset: write x5=0xDEAD, claim x6, pulse rst_n low → rs=5 reads 0, rbusy=0, pending_count=0, claim_ready=1.
- Bypass/x0: we[0]=1, wd[0]=3, wdata=0x1234 with rs[0]=3, rs[1]=0 → rdata[0]=0x1234 same cycle, rdata[1]=0; next cycle stored value 0x1234; writing x0=0xFF leaves x0 reading 0.
- Write collision: ports 0 and 1 both write x7 (0xAAAA, 0xBBBB) → bypass and stored value 0xBBBB.
- Scoreboard: claim x10 → next cycle rbusy=1 for rs=10, pending_count=1, claim x10 again gives claim_ready=0; write x10=0x42 → rbusy=0 same cycle, rdata=0x42, pending_count=0 next cycle.
- Claim vs clearing write same cycle on x12 (already pending) → claim_ready=1, next cycle pending still 1, stored data updated, pending_count unchanged.
- Fill: claim x1..x31 sequentially → pending_count=31; claim x0 accepted with no count change.
